// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: 2-flop synchroniser, glitch-rejecting start
// detection, mid-bit sampling and a one-entry valid/ready holding register.
module uart_rx_os #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 parity_err_o,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);
  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int BW   = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_HALF  = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_BREAK  = 3'd5
  } state_e;

  function automatic logic parity_error(input logic [DATA_BITS-1:0] data,
                                        input logic                 pbit);
    logic ones;
    ones = ^{data, pbit};
    if (PARITY == 1) begin
      return (ones == 1'b0);
    end else if (PARITY == 2) begin
      return (ones == 1'b1);
    end else begin
      return 1'b0;
    end
  endfunction

  state_e               state_q;
  logic                 sync1_q, sync2_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_idx_q;
  logic                 stop_idx_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_err_q, frm_err_q, done_q, busy_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;
  logic                 rx_s;
  logic                 frm_err_d;

  assign rx_s      = sync2_q;
  assign frm_err_d = frm_err_q | ~rx_s;

  // Synchroniser and frame FSM; done_q flags a finished frame for one clock.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      shreg_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (!rx_s) begin
            state_q <= S_START;
            busy_q  <= 1'b1;
          end
        end
        S_START: begin
          if (cnt_q == CNT_HALF) begin
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            stop_idx_q <= 1'b0;
            if (!rx_s) begin
              state_q <= S_DATA;
            end else begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_DATA: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q   <= '0;
            shreg_q <= {rx_s, shreg_q[DATA_BITS-1:1]};
            if (bit_idx_q == BIT_LAST) begin
              bit_idx_q <= '0;
              state_q   <= (PARITY != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + BW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_PARITY: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q     <= '0;
            par_err_q <= parity_error(shreg_q, rx_s);
            state_q   <= S_STOP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_STOP: begin
          if (cnt_q == CNT_FULL) begin
            cnt_q     <= '0;
            frm_err_q <= frm_err_d;
            if (stop_idx_q == STOP_LAST) begin
              done_q     <= 1'b1;
              stop_idx_q <= 1'b0;
              if (frm_err_d) begin
                state_q <= S_BREAK;
              end else begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              stop_idx_q <= stop_idx_q + 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BREAK: begin
          // A held-low line waits here so it cannot spawn repeated frames.
          if (rx_s) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // One-entry holding register with overrun detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= 1'b0;
      if (done_q) begin
        if (!valid_q || ready_i) begin
          data_q  <= shreg_q;
          perr_q  <= par_err_q;
          ferr_q  <= frm_err_q;
          valid_q <= 1'b1;
        end else begin
          ovr_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_q;
      end
    end
  end

  assign data_o       = data_q;
  assign valid_o      = valid_q;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overrun_o    = ovr_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 instance and a 7E1 instance, both at 16x.
module tb_uart_rx_os;
  localparam int CPB = 16;

  typedef struct packed {
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } word_t;

  typedef struct {
    int         sel;
    logic [8:0] din;
    logic       bad_par;
    logic       bad_stop;
    logic [8:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx0, rx1, ready0, ready1;
  logic [7:0] data0;
  logic [6:0] data1;
  logic       valid0, perr0, ferr0, ovr0, busy0;
  logic       valid1, perr1, ferr1, ovr1, busy1;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  word_t q0[$];
  word_t q1[$];
  word_t exp_q[$];
  int    rise0 = 0, vhigh0 = 0, busy_cnt0 = 0, ovr_cnt0 = 0, ovr_cnt1 = 0;
  logic  vprev0 = 1'b0;
  int    start_cyc = 0;
  logic  last_pbit = 1'b0;

  uart_rx_os dut (
    .clk(clk), .resetn(resetn), .rx(rx0), .data_o(data0), .valid_o(valid0),
    .ready_i(ready0), .parity_err_o(perr0), .frame_err_o(ferr0),
    .overrun_o(ovr0), .busy_o(busy0)
  );

  uart_rx_os #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .resetn(resetn), .rx(rx1), .data_o(data1), .valid_o(valid1),
    .ready_i(ready1), .parity_err_o(perr1), .frame_err_o(ferr1),
    .overrun_o(ovr1), .busy_o(busy1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: collects accepted words and counts pulses away from the active edge.
  always @(negedge clk) begin
    if (valid0 && !vprev0) rise0 = cyc;
    if (valid0) vhigh0++;
    if (valid0 && ready0) q0.push_back({1'b0, data0, perr0, ferr0});
    if (busy0) busy_cnt0++;
    if (ovr0) ovr_cnt0++;
    vprev0 = valid0;
    if (valid1 && ready1) q1.push_back({2'b00, data1, perr1, ferr1});
    if (ovr1) ovr_cnt1++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: actual=%0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx0 = v;
    else rx1 = v;
  endtask

  task automatic drive_bit(input int sel, input logic v);
    set_line(sel, v);
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [8:0] din, input logic bad_par,
                            input logic bad_stop, input int hold_low);
    int nb;
    nb = (sel == 0) ? 8 : 7;
    start_cyc = cyc;
    drive_bit(sel, 1'b0);
    for (int i = 0; i < nb; i++) drive_bit(sel, din[i]);
    if (sel == 1) begin
      last_pbit = (^din[6:0]) ^ bad_par;
      drive_bit(sel, last_pbit);
    end
    drive_bit(sel, ~bad_stop);
    for (int i = 0; i < hold_low; i++) drive_bit(sel, 1'b0);
    if (hold_low == 0) set_line(sel, 1'b1);
  endtask

  task automatic wait_word(input int sel, output word_t w, output logic ok);
    int n;
    n  = 0;
    ok = 1'b0;
    w  = '0;
    while (n < 400) begin
      if (sel == 0 && q0.size() > 0) begin
        w = q0.pop_front(); ok = 1'b1; break;
      end
      if (sel == 1 && q1.size() > 0) begin
        w = q1.pop_front(); ok = 1'b1; break;
      end
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t  tbl[8];
    word_t w, e;
    logic  ok;
    int    v0, b0, o0, sel, gap;
    logic  [8:0] d;
    logic  bp, bs;

    tbl[0] = '{0, 9'h05A, 1'b0, 1'b0, 9'h05A, 1'b0, 1'b0};
    tbl[1] = '{0, 9'h0FF, 1'b0, 1'b1, 9'h0FF, 1'b0, 1'b1};
    tbl[2] = '{0, 9'h000, 1'b0, 1'b0, 9'h000, 1'b0, 1'b0};
    tbl[3] = '{1, 9'h041, 1'b0, 1'b0, 9'h041, 1'b0, 1'b0};
    tbl[4] = '{1, 9'h041, 1'b1, 1'b0, 9'h041, 1'b1, 1'b0};
    tbl[5] = '{1, 9'h07F, 1'b0, 1'b0, 9'h07F, 1'b0, 1'b0};
    tbl[6] = '{1, 9'h07F, 1'b1, 1'b0, 9'h07F, 1'b1, 1'b0};
    tbl[7] = '{1, 9'h02A, 1'b0, 1'b1, 9'h02A, 1'b0, 1'b1};

    resetn = 1'b0; rx0 = 1'b1; rx1 = 1'b1; ready0 = 1'b1; ready1 = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs_8n1", {data0, valid0, perr0, ferr0, ovr0, busy0}, 0);
    check("reset_outputs_7e1", {data1, valid1, perr1, ferr1, ovr1, busy1}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(5);

    // 0xA5 8N1 with latency and single-cycle valid
    v0 = vhigh0;
    send_frame(0, 9'h0A5, 1'b0, 1'b0, 0);
    wait_word(0, w, ok);
    check("a5_arrive", ok, 1);
    check("a5_data", w.d, 9'h0A5);
    check("a5_flags", {w.pe, w.fe}, 0);
    check_rng("a5_latency", rise0 - start_cyc, 155, 157);
    idle(4);
    check("a5_valid_one_clock", vhigh0 - v0, 1);

    // 7-cycle glitch
    b0 = busy_cnt0; v0 = vhigh0;
    rx0 = 1'b0;
    idle(7);
    rx0 = 1'b1;
    idle(40);
    check_rng("glitch_busy_clks", busy_cnt0 - b0, 7, 9);
    check("glitch_no_valid", vhigh0 - v0, 0);

    for (int k = 0; k < 8; k++) begin
      send_frame(tbl[k].sel, tbl[k].din, tbl[k].bad_par, tbl[k].bad_stop, 0);
      wait_word(tbl[k].sel, w, ok);
      idle(2 * CPB);
      check($sformatf("tbl%0d_arrive", k), ok, 1);
      check($sformatf("tbl%0d_data", k), w.d, tbl[k].exp_d);
      check($sformatf("tbl%0d_perr", k), w.pe, tbl[k].exp_pe);
      check($sformatf("tbl%0d_ferr", k), w.fe, tbl[k].exp_fe);
    end

    // Break: stop bit low, line held low for 40 bit times
    send_frame(0, 9'h000, 1'b0, 1'b1, 40);
    @(negedge clk);
    check("break_busy_held", busy0, 1);
    wait_word(0, w, ok);
    check("break_word", ok, 1);
    check("break_word_flags", {w.d, w.fe}, {9'h000, 1'b1});
    check("break_single_word", q0.size(), 0);
    rx0 = 1'b1;
    idle(6);
    check("break_released", busy0, 0);
    check("break_no_repeat", q0.size(), 0);
    send_frame(0, 9'h03C, 1'b0, 1'b0, 0);
    wait_word(0, w, ok);
    check("after_break_word", {ok, w}, {1'b1, 9'h03C, 1'b0, 1'b0});

    // Overrun: consumer stalled, two back-to-back frames
    idle(CPB);
    ready0 = 1'b0;
    o0 = ovr_cnt0;
    send_frame(0, 9'h011, 1'b0, 1'b0, 0);
    send_frame(0, 9'h022, 1'b0, 1'b0, 0);
    idle(CPB);
    check("ovr_valid_held", valid0, 1);
    check("ovr_data_kept", data0, 8'h11);
    check("ovr_pulse_count", ovr_cnt0 - o0, 1);
    ready0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ovr_valid_drops", valid0, 0);
    wait_word(0, w, ok);
    check("ovr_accepted_word", {ok, w}, {1'b1, 9'h011, 1'b0, 1'b0});
    idle(CPB);

    // Reset mid-DATA of 0x5A
    rx0 = 1'b0; idle(CPB);
    rx0 = 1'b0; idle(CPB);
    rx0 = 1'b1; idle(CPB);
    rx0 = 1'b0; idle(CPB);
    resetn = 1'b0;
    rx0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_outputs", {data0, valid0, perr0, ferr0, ovr0, busy0}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(4 * CPB);
    check("midreset_nothing_delivered", {valid0, 32'(q0.size())}, 0);
    send_frame(0, 9'h096, 1'b0, 1'b0, 0);
    wait_word(0, w, ok);
    check("midreset_next_frame", {ok, w}, {1'b1, 9'h096, 1'b0, 1'b0});

    // Randomized frames against the reference model
    for (int k = 0; k < 24; k++) begin
      sel = $urandom_range(0, 1);
      d   = 9'($urandom);
      bp  = ($urandom_range(0, 3) == 0);
      bs  = ($urandom_range(0, 5) == 0);
      gap = $urandom_range(0, 20);
      if (bs && gap < 2) gap = 2;
      send_frame(sel, d, bp, bs, 0);
      if (sel == 0) begin
        e.d  = {1'b0, d[7:0]};
        e.pe = 1'b0;
      end else begin
        e.d  = {2'b00, d[6:0]};
        e.pe = (($countones({d[6:0], last_pbit}) % 2) == 1);
      end
      e.fe = bs;
      exp_q.push_back(e);
      wait_word(sel, w, ok);
      e = exp_q.pop_front();
      check($sformatf("rand%0d_arrive", k), ok, 1);
      check($sformatf("rand%0d_word", k), w, e);
      if (gap > 0) idle(gap);
    end

    idle(2 * CPB);
    check("p_no_overrun", ovr_cnt1, 0);
    check("final_idle", {busy0, busy1}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
